// File: rtl/multi_chain_scan_ctrl.sv
// Multi-chain boundary-scan sequencer: per-chain length table plus one
// capture/shift/update pass on the selected chain, with registered controls.
module multi_chain_scan_ctrl #(
  parameter int NUM_CHAINS  = 4,
  parameter int SEL_W       = 2,
  parameter int LEN_W       = 8,
  parameter int DEFAULT_LEN = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic [SEL_W-1:0] cfg_addr,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             start,
  input  logic [SEL_W-1:0] chain_sel,
  input  logic             mode_req,
  input  logic             abort,
  input  logic             scan_si,
  input  logic             chain_do,
  output logic [SEL_W-1:0] mux_select,
  output logic             capture_en,
  output logic             shift_dr,
  output logic             update_en,
  output logic             mode,
  output logic             chain_di,
  output logic             so_bit,
  output logic             so_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_tab [NUM_CHAINS];
  logic [LEN_W-1:0] sel_len;
  logic             sel_ok;
  logic             accept;
  logic             err_d;

  // Table lookup by match so that an out-of-range select simply finds nothing.
  always_comb begin
    sel_len = '0;
    sel_ok  = 1'b0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (chain_sel == SEL_W'(i)) begin
        sel_ok  = 1'b1;
        sel_len = len_tab[i];
      end
    end
  end

  assign accept = (state_q == S_IDLE) && start && sel_ok && (sel_len != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (accept) begin
            state_d = S_CAPTURE;
            cnt_d   = sel_len - LEN_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_UPDATE;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      S_UPDATE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mux_select <= '0;
      mode       <= 1'b0;
      capture_en <= 1'b0;
      shift_dr   <= 1'b0;
      update_en  <= 1'b0;
      chain_di   <= 1'b0;
      so_bit     <= 1'b0;
      so_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < NUM_CHAINS; i++) len_tab[i] <= LEN_W'(DEFAULT_LEN);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NUM_CHAINS; i++) begin
        if (cfg_wr && (cfg_addr == SEL_W'(i))) len_tab[i] <= cfg_len;
      end
      if (accept) begin
        mux_select <= chain_sel;
        mode       <= mode_req;
      end
      capture_en <= (state_d == S_CAPTURE);
      shift_dr   <= (state_d == S_SHIFT);
      update_en  <= (state_d == S_UPDATE);
      chain_di   <= (state_d == S_SHIFT) && scan_si;
      so_bit     <= (state_d == S_SHIFT) && chain_do;
      so_valid   <= (state_d == S_SHIFT);
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_multi_chain_scan_ctrl.sv
// Bench for multi_chain_scan_ctrl: timeline-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_multi_chain_scan_ctrl;

  localparam int NC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_len = '0;
  logic       start = 1'b0;
  logic [1:0] chain_sel = '0;
  logic       mode_req = 1'b0;
  logic       abort = 1'b0;
  logic       scan_si = 1'b0;
  logic       do_rnd = 1'b0;
  logic       loop_en = 1'b0;
  logic       chain_do;

  logic [1:0] mux_select;
  logic       capture_en, shift_dr, update_en, mode, chain_di, so_bit, so_valid;
  logic       busy, done, err;

  logic [1:0] mux_select3;
  logic       capture_en3, shift_dr3, update_en3, mode3, chain_di3, so_bit3, so_valid3;
  logic       busy3, done3, err3;

  assign chain_do = loop_en ? chain_di : do_rnd;

  multi_chain_scan_ctrl u_dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .start(start), .chain_sel(chain_sel), .mode_req(mode_req), .abort(abort),
    .scan_si(scan_si), .chain_do(chain_do), .mux_select(mux_select),
    .capture_en(capture_en), .shift_dr(shift_dr), .update_en(update_en), .mode(mode),
    .chain_di(chain_di), .so_bit(so_bit), .so_valid(so_valid), .busy(busy),
    .done(done), .err(err)
  );

  multi_chain_scan_ctrl #(.NUM_CHAINS(3)) u_dut3 (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .start(start), .chain_sel(chain_sel), .mode_req(mode_req), .abort(abort),
    .scan_si(scan_si), .chain_do(do_rnd), .mux_select(mux_select3),
    .capture_en(capture_en3), .shift_dr(shift_dr3), .update_en(update_en3), .mode(mode3),
    .chain_di(chain_di3), .so_bit(so_bit3), .so_valid(so_valid3), .busy(busy3),
    .done(done3), .err(err3)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // A scan is a timeline anchored at its start edge T: offset 1 capture,
  // 2..L+1 shift, L+2 update, L+3 done.
  int cyc = 0;
  int tab [NC];
  bit active = 0;
  int m_t0 = 0, m_len = 0, k = 0;
  logic [1:0] m_sel = '0;
  logic m_mode = 1'b0;
  logic e_cap = 0, e_shift = 0, e_upd = 0, e_done = 0, e_err = 0, e_busy = 0;
  logic e_di = 0, e_so = 0;
  logic cur_do;
  logic [12:0] exp_vec, act_vec;

  // observation counters for the directed scenarios
  int cnt_cap, cnt_shift, cnt_upd, cnt_done, cnt_err, cnt_busy, cnt_hold;
  int cnt_err3, cnt_cap3, done_off, err_off, start_edge;
  logic [7:0] di_hist, so_hist;

  task automatic clr_cnt();
    cnt_cap = 0; cnt_shift = 0; cnt_upd = 0; cnt_done = 0; cnt_err = 0;
    cnt_busy = 0; cnt_hold = 0; cnt_err3 = 0; cnt_cap3 = 0;
    done_off = -1; err_off = -1; di_hist = '0; so_hist = '0;
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    cur_do = loop_en ? e_di : do_rnd;
    e_err = 1'b0;
    if (!reset) begin
      active = 0;
      m_sel = '0;
      m_mode = 1'b0;
      for (int i = 0; i < NC; i++) tab[i] = 6;
    end else begin
      if (active) begin
        k = cyc - m_t0;
        if (abort && k <= m_len + 1) begin
          active = 0;
          e_err = 1'b1;
        end else if (k == m_len + 3) begin
          active = 0;
        end
      end else if (start) begin
        if (int'(chain_sel) < NC && tab[chain_sel] != 0) begin
          active = 1;
          m_t0 = cyc;
          m_len = tab[chain_sel];
          m_sel = chain_sel;
          m_mode = mode_req;
        end else begin
          e_err = 1'b1;
        end
      end
      if (cfg_wr && int'(cfg_addr) < NC) tab[cfg_addr] = int'(cfg_len);
    end
    k = cyc + 1 - m_t0;
    e_busy  = active;
    e_cap   = active && k == 1;
    e_shift = active && k >= 2 && k <= m_len + 1;
    e_upd   = active && k == m_len + 2;
    e_done  = active && k == m_len + 3;
    e_di    = e_shift && scan_si;
    e_so    = e_shift && cur_do;
    exp_vec = {m_sel, m_mode, e_cap, e_shift, e_upd, e_done, e_err, e_busy,
               e_di, e_so, e_shift};

    #1;
    act_vec = {mux_select, mode, capture_en, shift_dr, update_en, done, err, busy,
               chain_di, so_bit, so_valid};
    chk("cycle_outputs", int'(act_vec), int'(exp_vec));

    if (capture_en) cnt_cap++;
    if (shift_dr) begin
      cnt_shift++;
      di_hist = {di_hist[6:0], chain_di};
    end
    if (so_valid) so_hist = {so_hist[6:0], so_bit};
    if (update_en) cnt_upd++;
    if (done) begin cnt_done++; done_off = cyc - start_edge + 1; end
    if (err) begin cnt_err++; err_off = cyc - start_edge + 1; end
    if (busy) cnt_busy++;
    if (busy && mux_select == 2'd2 && mode) cnt_hold++;
    if (err3) cnt_err3++;
    if (capture_en3) cnt_cap3++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [1:0] sel, input logic m);
    start = 1'b1; chain_sel = sel; mode_req = m;
    start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_cfg(input logic [1:0] a, input logic [7:0] l);
    cfg_wr = 1'b1; cfg_addr = a; cfg_len = l;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr_cnt();
    start_edge = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_mux", int'(mux_select), 0);

    // default-length scan
    clr_cnt();
    do_start(2'd2, 1'b1);
    repeat (12) @(negedge clk);
    chk("def_cap", cnt_cap, 1);
    chk("def_shift", cnt_shift, 6);
    chk("def_upd", cnt_upd, 1);
    chk("def_done_off", done_off, 9);
    chk("def_busy", cnt_busy, 9);
    chk("def_hold", cnt_hold, 9);
    chk("def_mux_idle", int'(mux_select), 2);

    // programmed length with loopback data
    do_cfg(2'd1, 8'd3);
    clr_cnt();
    loop_en = 1'b1;
    do_start(2'd1, 1'b0);
    scan_si = 1'b1; @(negedge clk);
    scan_si = 1'b0; @(negedge clk);
    scan_si = 1'b1; @(negedge clk);
    scan_si = 1'b0;
    repeat (8) @(negedge clk);
    loop_en = 1'b0;
    chk("lb_shift", cnt_shift, 3);
    chk("lb_di", int'(di_hist[2:0]), 3'b101);
    chk("lb_so", int'(so_hist[2:0]), 3'b010);
    chk("lb_done_off", done_off, 6);

    // rejected starts: zero length, and out-of-range chain on the 3-chain instance
    do_cfg(2'd3, 8'd0);
    clr_cnt();
    do_start(2'd3, 1'b1);
    repeat (4) @(negedge clk);
    chk("rej_err", cnt_err, 1);
    chk("rej_err_off", err_off, 1);
    chk("rej_busy", cnt_busy, 0);
    chk("rej_err3", cnt_err3, 1);
    chk("rej_cap3", cnt_cap3, 0);

    // abort during the third shift cycle
    clr_cnt();
    do_start(2'd0, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    chk("abort_shift", cnt_shift, 3);
    chk("abort_upd", cnt_upd, 0);
    chk("abort_done", cnt_done, 0);
    chk("abort_err", cnt_err, 1);
    clr_cnt();
    do_start(2'd0, 1'b1);
    repeat (12) @(negedge clk);
    chk("post_abort_shift", cnt_shift, 6);
    chk("post_abort_done", cnt_done, 1);

    // reset mid-shift, then table must be back to default
    clr_cnt();
    do_start(2'd0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst_shift", int'(shift_dr), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_upd", cnt_upd, 0);
    chk("rst_done", cnt_done, 0);
    clr_cnt();
    do_start(2'd1, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; chain_sel = 2'd2;
    cfg_wr = 1'b1; cfg_addr = 2'd1; cfg_len = 8'd10;
    @(negedge clk);
    start = 1'b0; cfg_wr = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_shift", cnt_shift, 6);
    chk("busy_done_off", done_off, 9);
    chk("busy_mux", int'(mux_select), 1);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 5) == 0);
      chain_sel = 2'($urandom_range(0, 3));
      mode_req  = 1'($urandom_range(0, 1));
      abort     = ($urandom_range(0, 29) == 0);
      cfg_wr    = ($urandom_range(0, 14) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_len   = 8'($urandom_range(0, 7));
      scan_si   = 1'($urandom_range(0, 1));
      do_rnd    = 1'($urandom_range(0, 1));
      loop_en   = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; cfg_wr = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
